// File: rtl/instr_mem_pkg.sv
// Shared sizing for the instruction store.
// Holds the default word/byte/depth geometry, the bytes-per-word count and
// the index widths derived from them.
package instr_mem_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int BYTE_WIDTH     = 8;
    localparam int MEM_DEPTH      = 1024;
    localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
    // Byte index width into the array and byte-offset width inside a word.
    localparam int IDX_W          = $clog2(MEM_DEPTH);
    localparam int OFF_W          = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/instruction_memory_if.sv
// Fetch/load bus of the instruction store.
//   a       : read byte address (PC), driven by the fetch side
//   rd      : instruction read at a, driven by the memory
//   dir     : write byte address
//   data_in : word to write
//   we      : write enable
// master = fetch/loader side, slave = memory side.
interface instruction_memory_if
    import instr_mem_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH,
    parameter int IW = IDX_W
);
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    logic [IW-1:0] dir;
    logic [DW-1:0] data_in;
    logic          we;

    modport master (output a, output dir, output data_in, output we, input rd);
    modport slave  (input a, input dir, input data_in, input we, output rd);
endinterface

// File: rtl/instruction_memory.sv
// Byte-organized, word-accessed instruction store.
// Combinational little-endian word read at the PC byte address, synchronous
// word write for program loading, asynchronous active-high clear of the
// whole array.
// Ports:
//   clk : clock, writes on the rising edge
//   rst : asynchronous active-high reset, clears every byte
//   bus : instruction_memory_if.slave (a, rd, dir, data_in, we)
module instruction_memory
#(
    parameter int DATA_WIDTH = instr_mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = instr_mem_pkg::ADDR_WIDTH,
    parameter int BYTE_WIDTH = instr_mem_pkg::BYTE_WIDTH,
    parameter int MEM_DEPTH  = instr_mem_pkg::MEM_DEPTH
)(
    input  logic                 clk,
    input  logic                 rst,
    instruction_memory_if.slave  bus
);
    import instr_mem_pkg::*;

    localparam int BPW    = DATA_WIDTH / BYTE_WIDTH;
    localparam int IW     = $clog2(MEM_DEPTH);
    localparam int OW     = $clog2(BPW);
    localparam int WORD_W = IW - OW;

    logic [BYTE_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Word indices: byte-offset bits are dropped so every access hits the
    // aligned word; PC bits above the array size are dropped so reads wrap.
    logic [WORD_W-1:0] rword;
    logic [WORD_W-1:0] wword;
    assign rword = bus.a[IW-1:OW];
    assign wword = bus.dir[IW-1:OW];

    // Address bits that deliberately play no part in the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a[ADDR_WIDTH-1:IW], bus.a[OW-1:0], bus.dir[OW-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.we) begin
            for (int l = 0; l < BPW; l++) begin
                mem_q[{wword, OW'(l)}] <= bus.data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Little-endian assembly: lowest byte address supplies the LSBs.
    always_comb begin
        bus.rd = '0;
        for (int l = 0; l < BPW; l++) begin
            bus.rd[l*BYTE_WIDTH +: BYTE_WIDTH] = mem_q[{rword, OW'(l)}];
        end
    end
endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    instruction_memory_if bus ();

    instruction_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a plain byte array addressed with modular arithmetic.
    logic [7:0] ref_mem [1024];

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int unsigned b;
        b = (addr % 1024) / 4 * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] w);
        int unsigned b;
        b = (addr % 1024) / 4 * 4;
        for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive a write between edges, let one rising edge capture it.
    task automatic write_word(input logic [9:0] d, input logic [31:0] w);
        @(negedge clk);
        bus.dir = d;
        bus.data_in = w;
        bus.we = 1'b1;
        @(posedge clk);
        if (!rst) ref_write({22'd0, d}, w);
        #1;
        bus.we = 1'b0;
    endtask

    logic [31:0] prog [10];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        prog = '{32'h00000513, 32'h00100593, 32'h00A00613, 32'h00060C63, 32'h00B502B3,
                 32'h00B00533, 32'h005005B3, 32'hFFF60613, 32'hFEDFF06F, 32'h0000006F};
        ref_clear();
        bus.a = '0;
        bus.dir = '0;
        bus.data_in = '0;
        bus.we = 1'b0;
        rst = 1'b1;

        // Reset: whole array reads zero.
        #2;
        for (int ad = 0; ad <= 32'h3FC; ad += 4) begin
            bus.a = ad;
            #1;
            check("reset_sweep", bus.rd, 32'h0);
        end
        // Write pulse during reset is ignored.
        write_word(10'd0, 32'hFFFFFFFF);
        bus.a = 0;
        #1;
        check("write_in_reset", bus.rd, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Program load and readback.
        for (int i = 0; i < 10; i++) write_word(10'(4*i), prog[i]);
        for (int i = 0; i < 10; i++) begin
            bus.a = 4*i;
            #1;
            check("prog_readback", bus.rd, ref_read(bus.a));
        end
        bus.a = 32;
        #1;
        check("prog_a32", bus.rd, 32'hFEDFF06F);

        // Alignment and wrap.
        bus.a = 32'h6;
        #1;
        check("align_a6", bus.rd, 32'h00100593);
        bus.a = 32'h00000408;
        #1;
        check("wrap_a408", bus.rd, 32'h00A00613);
        bus.a = 32'hABCD_0408;
        #1;
        check("wrap_upper", bus.rd, 32'h00A00613);
        write_word(10'h00B, 32'hCAFEF00D);
        bus.a = 32'h8;
        #1;
        check("unaligned_write", bus.rd, 32'hCAFEF00D);
        check("unaligned_write_ref", bus.rd, ref_read(32'h8));
        bus.a = 32'hC;
        #1;
        check("neighbour_intact", bus.rd, 32'h00060C63);

        // Write enable low holds the array.
        @(negedge clk);
        bus.a = 4;
        bus.dir = 10'd4;
        bus.data_in = 32'hDEADBEEF;
        bus.we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("we_low_hold", bus.rd, 32'h00100593);
        end

        // Same-address write: old data before the edge, new after it.
        @(negedge clk);
        bus.a = 12;
        bus.dir = 10'd12;
        bus.data_in = 32'h12345678;
        bus.we = 1'b1;
        #1;
        check("pre_edge_old", bus.rd, 32'h00060C63);
        @(posedge clk);
        ref_write(32'd12, 32'h12345678);
        #1;
        check("post_edge_new", bus.rd, 32'h12345678);
        bus.we = 1'b0;

        // Randomized traffic against the reference.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            bus.dir = 10'($urandom_range(0, 1023));
            bus.data_in = $urandom;
            bus.we = ($urandom_range(0, 3) != 0);
            bus.a = ($urandom_range(0, 1) != 0) ? {22'($urandom), bus.dir} : $urandom;
            #1;
            check("rand_pre", bus.rd, ref_read(bus.a));
            @(posedge clk);
            if (bus.we) ref_write({22'd0, bus.dir}, bus.data_in);
            #1;
            check("rand_post", bus.rd, ref_read(bus.a));
        end
        @(negedge clk);
        bus.we = 1'b0;

        // Asynchronous reset mid-operation.
        bus.a = 32;
        write_word(10'd32, 32'hFEDFF06F);
        bus.a = 32;
        #1;
        check("before_async_rst", bus.rd, 32'hFEDFF06F);
        @(negedge clk);
        #2;
        rst = 1'b1;
        ref_clear();
        #1;
        check("async_rst_immediate", bus.rd, 32'h0);
        write_word(10'd32, 32'h11111111);
        bus.a = 32;
        #1;
        check("write_during_rst2", bus.rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int ad = 0; ad <= 32'h3FC; ad += 4) begin
            bus.a = ad;
            #1;
            check("post_rst_sweep", bus.rd, ref_read(bus.a));
        end
        write_word(10'd20, 32'h00B502B3);
        bus.a = 20;
        #1;
        check("rewrite_after_rst", bus.rd, 32'h00B502B3);
        bus.a = 24;
        #1;
        check("other_still_zero", bus.rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_memory.md
# instruction_memory

Byte-organized, word-accessed instruction store for the single-cycle RISC-V Fibonacci core. The fetch stage reads a 32-bit instruction combinationally at the PC byte address. A separate synchronous write port loads the program before execution. Asynchronous reset clears the whole array.

## Interface
- DATA_WIDTH, 32, instruction/word width in bits (multiple of BYTE_WIDTH).
- ADDR_WIDTH, 32, read-address (PC) width.
- BYTE_WIDTH, 8, width of one storage location.
- MEM_DEPTH, 1024, number of byte locations (power of two; 256 words at defaults).
- Clocking/reset (fixed): one clock; reset is asynchronous and active-high.
- clk  input  1  clock; writes on rising edge.
- rst  input  1  asynchronous active-high reset.
- a  input  ADDR_WIDTH  read byte address (PC).
- rd  output  DATA_WIDTH  instruction read at `a`.
- dir  input  $clog2(MEM_DEPTH) (10)  write byte address.
- data_in  input  DATA_WIDTH  word to write.
- we  input  1  write enable.

## Operation
- Storage: MEM_DEPTH bytes of BYTE_WIDTH bits. Words are little-endian: byte at word base holds bits [7:0], base+3 holds bits [31:24].
- Alignment: the low log2(DATA_WIDTH/BYTE_WIDTH) bits (2) of `a` and `dir` are ignored. Every access targets the aligned word.
- Read index: `a` is truncated to its low $clog2(MEM_DEPTH) bits, so `a` wraps modulo MEM_DEPTH. Upper PC bits are ignored.
- Read: rd = {mem[base+3], mem[base+2], mem[base+1], mem[base]}. The read is purely combinational and has no enable.
- Write: on the rising clk edge with we=1 and rst=0, all four bytes of the aligned word at `dir` take data_in. With we=0 the array holds.
- Reset: while rst=1 every byte is 0, so rd=0 for all `a`. Writes are ignored during reset. Reset asserted in the middle of a load discards all words written before it.
- No initial-file preload. Program content comes only through the write port.

## Timing
- Read latency 0: rd follows `a` and the array contents combinationally, within the same cycle.
- Write latency 1: data is visible on rd immediately after the rising edge that captures it.
- Same-address read/write: rd shows old data before the edge and new data after it. There is no bypass before the edge.
- Reset assertion clears the array asynchronously, independent of clk. Deassertion is synchronized externally.
- we, dir and data_in must be stable around the rising edge. There is no handshake and no busy state.

## Structure
- Package instr_mem_pkg holds DATA_WIDTH, BYTE_WIDTH, MEM_DEPTH defaults, BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH, and the derived index widths.
- Implement as a single module:
  - one always_ff for the asynchronous reset/clear and the byte-lane write, generating BYTES_PER_WORD lanes;
  - one always_comb for the little-endian read assembly.
- No sub-module.

## Test plan
- Reset: assert rst, sweep a=0..0x3FC → rd=0x00000000 everywhere. A write pulse during rst leaves the address at 0.
- Program load/readback: write the Fibonacci program at dir=0,4,…,36:
  - 0x00000513, 0x00100593, 0x00A00613, 0x00060C63, 0x00B502B3;
  - 0x00B00533, 0x005005B3, 0xFFF60613, 0xFEDFF06F, 0x0000006F.
  - Then a=0,4,…,36 → rd returns the same words in order, e.g. a=32 → 0xFEDFF06F.
- Alignment/wrap:
  - a=0x6 → rd=0x00100593;
  - a=0x00000408 → rd=0x00A00613 (upper bits ignored);
  - write at dir=0x00B → the word at 0x008 changes.
- Write enable: we=0 with dir=4, data_in=0xDEADBEEF for several edges → rd at a=4 stays 0x00100593.
- Write-then-read timing: a=12 held, write 0x12345678 at dir=12 → rd shows the old 0x00060C63 until the edge, then 0x12345678.
- Reset mid-operation: after the load, pulse rst asynchronously between edges → rd drops to 0 immediately. Every address reads 0 afterwards until rewritten.
